// File: rtl/waterfall_writer.sv
`default_nettype none
// ============================================================================
//  Module      : waterfall_writer
//  Description : Captures one spectrum row from an SDFT core and writes it
//                into a circular waterfall framebuffer.
//                Pixel mapping: linear (magnitude >> SHIFT, saturated)
//                by default. Defining WATERFALL_LOG_EN selects a log2 mapping:
//                bit length of the magnitude, clamped to the pixel range.
//  Ports       : clk           - sole clock, rising edge
//                reset         - asynchronous, active-high
//                capture       - one-cycle request to grab one spectrum row
//                sdft_ready    - SDFT idle
//                sdft_bin_out  - magnitude returned by the SDFT
//                sdft_read     - read request to the SDFT
//                sdft_bin_addr - bin index to the SDFT
//                fb_we         - framebuffer write strobe
//                fb_addr       - framebuffer address (row * LIMIT_BINS + bin)
//                fb_data       - pixel value
//                head_row      - row most recently completed
//                busy          - row capture in progress
//                frame_done    - one-cycle pulse when the row pointer wraps
//                overrun       - one-cycle pulse when a capture is dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module waterfall_writer #(
    parameter int FREQ_W     = 16,
    parameter int LIMIT_BINS = 32,
    parameter int ROWS       = 32,
    parameter int PIX_W      = 4,
    parameter int SHIFT      = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              capture,
    input  logic                              sdft_ready,
    input  logic [FREQ_W-1:0]                 sdft_bin_out,
    output logic                              sdft_read,
    output logic [$clog2(LIMIT_BINS)-1:0]     sdft_bin_addr,
    output logic                              fb_we,
    output logic [$clog2(ROWS*LIMIT_BINS)-1:0] fb_addr,
    output logic [PIX_W-1:0]                  fb_data,
    output logic [$clog2(ROWS)-1:0]           head_row,
    output logic                              busy,
    output logic                              frame_done,
    output logic                              overrun
);

    localparam int c_BIN_W   = $clog2(LIMIT_BINS);
    localparam int c_ROW_W   = $clog2(ROWS);
    localparam int c_PIX_MAX = (1 << PIX_W) - 1;

    localparam logic [c_BIN_W-1:0] c_LAST_BIN = c_BIN_W'(LIMIT_BINS - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_REQ      = 3'd2,
        S_ISSUE    = 3'd3,
        S_DRAIN    = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [c_BIN_W-1:0]   r_bin_addr;
    logic                 r_drain_cnt;
    logic [c_ROW_W-1:0]   r_write_row;
    logic [c_ROW_W-1:0]   r_head_row;

    // Two-stage delay line: stage 1 is r_v1/r_a1, stage 2 is the fb register.
    logic                 r_v1;
    logic [c_BIN_W-1:0]   r_a1;
    logic                 r_fb_we;
    logic [c_ROW_W+c_BIN_W-1:0] r_fb_addr;
    logic [PIX_W-1:0]     r_fb_data;

    logic [PIX_W-1:0]     w_pix;

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and combinational outputs. Keeping sdft_read, busy and
    // the pulses purely state-decoded lets an asynchronous reset drop them
    // immediately without waiting for a clock edge.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        sdft_read    = 1'b0;
        busy         = 1'b1;
        frame_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (capture) begin
                    w_next_state = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (sdft_ready) begin
                    w_next_state = S_REQ;
                end
            end
            S_REQ: begin
                sdft_read    = 1'b1;
                w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                sdft_read = 1'b1;
                if (r_bin_addr == c_LAST_BIN) begin
                    w_next_state = S_DRAIN;
                end
            end
            S_DRAIN: begin
                sdft_read = 1'b1;
                if (r_drain_cnt) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                frame_done   = (r_write_row == c_LAST_ROW);
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Any capture outside IDLE (including DONE) is dropped.
        overrun = capture && (r_state != S_IDLE);
    end

    // ------------------------------------------------------------------------
    // Bin address counter, drain counter and row pointers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bin_addr  <= '0;
            r_drain_cnt <= 1'b0;
            r_write_row <= '0;
            r_head_row  <= c_LAST_ROW;
        end else begin
            // Second DRAIN cycle is flagged by r_drain_cnt.
            r_drain_cnt <= (r_state == S_DRAIN) && !r_drain_cnt;
            case (r_state)
                S_ISSUE: begin
                    // Saturates at the last bin so DRAIN holds it.
                    if (r_bin_addr != c_LAST_BIN) begin
                        r_bin_addr <= r_bin_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    r_bin_addr  <= '0;
                    r_head_row  <= r_write_row;
                    // ROWS is a power of two, so natural overflow wraps.
                    r_write_row <= r_write_row + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Capture pipeline. Stage 1 follows each issued address; stage 2 lands in
    // the framebuffer register together with the returned magnitude.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1      <= 1'b0;
            r_a1      <= '0;
            r_fb_we   <= 1'b0;
            r_fb_addr <= '0;
            r_fb_data <= '0;
        end else begin
            r_v1    <= (r_state == S_ISSUE);
            r_a1    <= r_bin_addr;
            r_fb_we <= r_v1;
            if (r_v1) begin
                // Concatenation equals write_row * LIMIT_BINS + bin.
                r_fb_addr <= {r_write_row, r_a1};
                r_fb_data <= w_pix;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pixel mapping
    // ------------------------------------------------------------------------
`ifdef WATERFALL_LOG_EN
    int w_len;

    // floor(log2(x)) + 1 is the bit length of x; zero maps to zero.
    always_comb begin
        w_len = 0;
        for (int i = 0; i < FREQ_W; i++) begin
            if (sdft_bin_out[i]) begin
                w_len = i + 1;
            end
        end
        if (w_len > c_PIX_MAX) begin
            w_pix = PIX_W'(c_PIX_MAX);
        end else begin
            w_pix = PIX_W'(w_len);
        end
    end
`else
    logic [FREQ_W-1:0] w_shift;

    always_comb begin
        w_shift = sdft_bin_out >> SHIFT;
        if (w_shift > FREQ_W'(c_PIX_MAX)) begin
            w_pix = PIX_W'(c_PIX_MAX);
        end else begin
            w_pix = w_shift[PIX_W-1:0];
        end
    end
`endif

    assign sdft_bin_addr = r_bin_addr;
    assign fb_we         = r_fb_we;
    assign fb_addr       = r_fb_addr;
    assign fb_data       = r_fb_data;
    assign head_row      = r_head_row;

endmodule
`default_nettype wire

// File: tb/tb_waterfall_writer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_waterfall_writer
//  Description : Directed self-checking bench for waterfall_writer with a
//                behavioural SDFT read model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_waterfall_writer;

    localparam int LIMIT_BINS = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        capture = 1'b0;
    logic        sdft_ready = 1'b1;
    logic [15:0] sdft_bin_out;
    logic        sdft_read;
    logic [4:0]  sdft_bin_addr;
    logic        fb_we;
    logic [9:0]  fb_addr;
    logic [3:0]  fb_data;
    logic [4:0]  head_row;
    logic        busy;
    logic        frame_done;
    logic        overrun;

    int n_total = 0;
    int n_bad   = 0;

    waterfall_writer dut (
        .clk          (clk),
        .reset        (reset),
        .capture      (capture),
        .sdft_ready   (sdft_ready),
        .sdft_bin_out (sdft_bin_out),
        .sdft_read    (sdft_read),
        .sdft_bin_addr(sdft_bin_addr),
        .fb_we        (fb_we),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .head_row     (head_row),
        .busy         (busy),
        .frame_done   (frame_done),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SDFT model: read sampled with ready enters read mode; in read mode the
    // address is registered and its magnitude is returned from that register.
    logic [15:0] mem [LIMIT_BINS];
    logic        mode = 1'b0;
    logic [4:0]  raddr = 5'd0;
    always @(posedge clk) begin
        mode <= sdft_read && (mode || sdft_ready);
        if (mode && sdft_read) raddr <= sdft_bin_addr;
    end
    assign sdft_bin_out = mem[raddr];

    // Monitor
    int wq_addr[$];
    int wq_data[$];
    int wq_cyc[$];
    int n_read = 0, first_read_cyc = 0, n_frame = 0, n_over = 0, over_cyc = 0, cap_cyc = 0;
    always @(negedge clk) begin
        if (fb_we) begin
            wq_addr.push_back(int'(fb_addr));
            wq_data.push_back(int'(fb_data));
            wq_cyc.push_back(cyc);
        end
        if (sdft_read) begin
            if (n_read == 0) first_read_cyc = cyc;
            n_read++;
        end
        if (frame_done) n_frame++;
        if (overrun) begin
            n_over++;
            over_cyc = cyc;
        end
        if (capture) cap_cyc = cyc;
    end

    // Pixel vectors
    logic [15:0] c_vec [10] = '{16'd0, 16'd1, 16'd16, 16'd17, 16'd31,
                                16'd32, 16'd240, 16'd255, 16'd256, 16'd65535};
`ifdef WATERFALL_LOG_EN
    logic [3:0]  c_exp [10] = '{4'd0, 4'd1, 4'd5, 4'd5, 4'd5, 4'd6, 4'd8, 4'd8, 4'd9, 4'd15};
`else
    logic [3:0]  c_exp [10] = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd15, 4'd15, 4'd15, 4'd15};
`endif

    task automatic clear_mon();
        wq_addr.delete();
        wq_data.delete();
        wq_cyc.delete();
        n_read = 0;
        n_over = 0;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < LIMIT_BINS; k++) mem[k] = 16'(16 * k);
    endtask

    task automatic pulse_capture();
        @(posedge clk);
        #1 capture = 1'b1;
        @(posedge clk);
        #1 capture = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int at);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_total++; if (sdft_read !== 1'b0) begin n_bad++; $display("FAIL reset_sdft_read: got %b expected 0", sdft_read); end
        n_total++; if (sdft_bin_addr !== 5'd0) begin n_bad++; $display("FAIL reset_bin_addr: got %0d expected 0", sdft_bin_addr); end
        n_total++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL reset_fb_we: got %b expected 0", fb_we); end
        n_total++; if (fb_addr !== 10'd0) begin n_bad++; $display("FAIL reset_fb_addr: got %0d expected 0", fb_addr); end
        n_total++; if (fb_data !== 4'd0) begin n_bad++; $display("FAIL reset_fb_data: got %0d expected 0", fb_data); end
        n_total++; if (head_row !== 5'd31) begin n_bad++; $display("FAIL reset_head_row: got %0d expected 31", head_row); end
        n_total++; if ({busy, frame_done, overrun} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b expected 000", {busy, frame_done, overrun}); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // First row with ramp data: bin k returns 16k, pixel = min(k, 15).
    // Capture high in cycle c; fb_we first in cycle c+5, four edges after the
    // sampling edge; DONE in cycle c+37, IDLE in c+38.
    task automatic test_row();
        bit ok;
        int at, c0;
        load_ramp();
        sdft_ready = 1'b1;
        clear_mon();
        pulse_capture();
        c0 = cap_cyc;
        wait_idle(100, ok, at);
        n_total++; if (!ok) begin n_bad++; $display("FAIL row_timeout: got busy expected idle"); end
        n_total++; if (wq_addr.size() != 32) begin n_bad++; $display("FAIL row_count: got %0d expected 32", wq_addr.size()); end
        for (int k = 0; k < wq_addr.size() && k < 32; k++) begin
            n_total++; if (wq_addr[k] != k) begin n_bad++; $display("FAIL row_addr[%0d]: got %0d expected %0d", k, wq_addr[k], k); end
            n_total++; if (wq_data[k] != ((k > 15) ? 15 : k)) begin n_bad++; $display("FAIL row_data[%0d]: got %0d expected %0d", k, wq_data[k], (k > 15) ? 15 : k); end
            n_total++; if (wq_cyc[k] != c0 + 5 + k) begin n_bad++; $display("FAIL row_we_cycle[%0d]: got %0d expected %0d", k, wq_cyc[k] - c0, 5 + k); end
        end
        n_total++; if (at != c0 + 38) begin n_bad++; $display("FAIL row_idle_cycle: got %0d expected 38", at - c0); end
        n_total++; if (n_read != 35) begin n_bad++; $display("FAIL row_read_cycles: got %0d expected 35", n_read); end
        n_total++; if (head_row !== 5'd0) begin n_bad++; $display("FAIL row_head: got %0d expected 0", head_row); end
    endtask

    task automatic test_wait_ready();
        bit ok;
        int at, rc;
        sdft_ready = 1'b0;
        clear_mon();
        pulse_capture();
        wait_cycles(10);
        n_total++; if (n_read != 0) begin n_bad++; $display("FAIL wait_read: got %0d expected 0", n_read); end
        n_total++; if (wq_addr.size() != 0) begin n_bad++; $display("FAIL wait_we: got %0d expected 0", wq_addr.size()); end
        n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wait_busy: got %b expected 1", busy); end
        sdft_ready = 1'b1;
        @(negedge clk);
        rc = cyc;
        #1;
        wait_idle(100, ok, at);
        n_total++; if (!ok) begin n_bad++; $display("FAIL wait_timeout: got busy expected idle"); end
        n_total++; if (first_read_cyc != rc + 1) begin n_bad++; $display("FAIL wait_start: got %0d expected 1", first_read_cyc - rc); end
        n_total++; if (wq_addr.size() != 32) begin n_bad++; $display("FAIL wait_count: got %0d expected 32", wq_addr.size()); end
        for (int k = 0; k < wq_addr.size() && k < 32; k++) begin
            n_total++; if (wq_addr[k] != 32 + k) begin n_bad++; $display("FAIL wait_addr[%0d]: got %0d expected %0d", k, wq_addr[k], 32 + k); end
        end
        n_total++; if (head_row !== 5'd1) begin n_bad++; $display("FAIL wait_head: got %0d expected 1", head_row); end
    endtask

    task automatic test_overrun();
        bit ok;
        int at, c0, c1;
        clear_mon();
        pulse_capture();
        c0 = cap_cyc;
        wait_cycles(10);
        pulse_capture();
        c1 = cap_cyc;
        n_total++; if (n_over != 1) begin n_bad++; $display("FAIL over_count: got %0d expected 1", n_over); end
        n_total++; if (over_cyc != c1) begin n_bad++; $display("FAIL over_cycle: got %0d expected %0d", over_cyc, c1); end
        wait_idle(100, ok, at);
        n_total++; if (!ok) begin n_bad++; $display("FAIL over_timeout: got busy expected idle"); end
        n_total++; if (at != c0 + 38) begin n_bad++; $display("FAIL over_idle_cycle: got %0d expected 38", at - c0); end
        wait_cycles(10);
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL over_second_row: got busy=%b expected 0", busy); end
        n_total++; if (wq_addr.size() != 32) begin n_bad++; $display("FAIL over_we_count: got %0d expected 32", wq_addr.size()); end
        n_total++; if (n_read != 35) begin n_bad++; $display("FAIL over_read_cycles: got %0d expected 35", n_read); end
        for (int k = 0; k < wq_addr.size() && k < 32; k++) begin
            n_total++; if (wq_addr[k] != 64 + k) begin n_bad++; $display("FAIL over_addr[%0d]: got %0d expected %0d", k, wq_addr[k], 64 + k); end
        end
        n_total++; if (head_row !== 5'd2) begin n_bad++; $display("FAIL over_head: got %0d expected 2", head_row); end
    endtask

    task automatic test_reset_mid();
        bit ok, found;
        int at;
        clear_mon();
        pulse_capture();
        found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sdft_read && sdft_bin_addr == 5'd10) begin
                found = 1'b1;
                break;
            end
        end
        n_total++; if (!found) begin n_bad++; $display("FAIL mid_bin10: got not found expected found"); end
        n_total++; if (fb_we !== 1'b1) begin n_bad++; $display("FAIL mid_we_before: got %b expected 1", fb_we); end
        #2 reset = 1'b1;
        #1;
        n_total++; if (sdft_read !== 1'b0) begin n_bad++; $display("FAIL mid_read_drop: got %b expected 0", sdft_read); end
        n_total++; if (fb_we !== 1'b0) begin n_bad++; $display("FAIL mid_we_drop: got %b expected 0", fb_we); end
        n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy_drop: got %b expected 0", busy); end
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_mon();
        wait_cycles(8);
        n_total++; if (wq_addr.size() != 0 || n_read != 0) begin n_bad++; $display("FAIL mid_quiet: got we=%0d read=%0d expected 0 0", wq_addr.size(), n_read); end
        clear_mon();
        pulse_capture();
        wait_idle(100, ok, at);
        n_total++; if (wq_addr.size() != 32) begin n_bad++; $display("FAIL mid_count: got %0d expected 32", wq_addr.size()); end
        for (int k = 0; k < wq_addr.size() && k < 32; k++) begin
            n_total++; if (wq_addr[k] != k) begin n_bad++; $display("FAIL mid_addr[%0d]: got %0d expected %0d", k, wq_addr[k], k); end
        end
        n_total++; if (head_row !== 5'd0) begin n_bad++; $display("FAIL mid_head: got %0d expected 0", head_row); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int at;
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_frame = 0;
        for (int r = 0; r < 32; r++) begin
            clear_mon();
            pulse_capture();
            wait_idle(100, ok, at);
            n_total++; if (!ok) begin n_bad++; $display("FAIL b2b_timeout[%0d]: got busy expected idle", r); end
            if (r == 30) begin
                n_total++; if (n_frame != 0) begin n_bad++; $display("FAIL b2b_early_frame: got %0d expected 0", n_frame); end
            end
        end
        n_total++; if (n_frame != 1) begin n_bad++; $display("FAIL b2b_frame: got %0d expected 1", n_frame); end
        n_total++; if (wq_addr.size() != 32) begin n_bad++; $display("FAIL b2b_count: got %0d expected 32", wq_addr.size()); end
        for (int k = 0; k < wq_addr.size() && k < 32; k++) begin
            n_total++; if (wq_addr[k] != 992 + k) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %0d expected %0d", k, wq_addr[k], 992 + k); end
        end
        n_total++; if (head_row !== 5'd31) begin n_bad++; $display("FAIL b2b_head: got %0d expected 31", head_row); end
        clear_mon();
        pulse_capture();
        wait_idle(100, ok, at);
        n_total++; if (wq_addr.size() != 32) begin n_bad++; $display("FAIL wrap_count: got %0d expected 32", wq_addr.size()); end
        for (int k = 0; k < wq_addr.size() && k < 32; k++) begin
            n_total++; if (wq_addr[k] != k) begin n_bad++; $display("FAIL wrap_addr[%0d]: got %0d expected %0d", k, wq_addr[k], k); end
        end
        n_total++; if (head_row !== 5'd0) begin n_bad++; $display("FAIL wrap_head: got %0d expected 0", head_row); end
        n_total++; if (n_frame != 1) begin n_bad++; $display("FAIL wrap_frame: got %0d expected 1", n_frame); end
    endtask

    task automatic test_pixel();
        bit ok;
        int at;
        for (int k = 0; k < LIMIT_BINS; k++) mem[k] = (k < 10) ? c_vec[k] : 16'd0;
        clear_mon();
        pulse_capture();
        wait_idle(100, ok, at);
        n_total++; if (wq_addr.size() != 32) begin n_bad++; $display("FAIL pix_count: got %0d expected 32", wq_addr.size()); end
        for (int k = 0; k < wq_addr.size() && k < 10; k++) begin
            n_total++; if (wq_data[k] != int'(c_exp[k])) begin n_bad++; $display("FAIL pix_data[%0d]: bin_out %0d got %0d expected %0d", k, c_vec[k], wq_data[k], c_exp[k]); end
            n_total++; if (wq_addr[k] != 32 + k) begin n_bad++; $display("FAIL pix_addr[%0d]: got %0d expected %0d", k, wq_addr[k], 32 + k); end
        end
    endtask

    initial begin
        load_ramp();
        test_reset();
        test_row();
        test_wait_ready();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_pixel();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
